uart_core_param: RTL
====================

Name: uart_core_param

Overview:
Parametrised full-duplex UART transceiver that replaces the fixed 8N1 `uart_top` pair. It supports configurable baud divisor, data width, parity mode and stop-bit count, and adds parity and framing error detection plus an internal loopback mode. It sits between host logic (a parallel handshake) and the serial pins `txd`/`rxd`.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be >= 4.
- DATA_BITS, 8: payload bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_start  in  1  request to send; honoured only while tx_busy=0.
- tx_data  in  DATA_BITS  payload; latched on the accepted tx_start cycle.
- tx_busy  out  1  transmitter occupied.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit.
- txd  out  1  serial output; idles high.
- rxd  in  1  serial input; asynchronous.
- loopback  in  1  when 1, the receiver takes the internal txd instead of rxd.
- rx_data  out  DATA_BITS  last received payload; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- rx_parity_err  out  1  parity mismatch for the current frame; qualified by rx_valid, held until the next rx_valid.
- rx_frame_err  out  1  some stop bit sampled low; qualified by rx_valid, held until the next rx_valid.

Behaviour:
- Reset values: txd=1, tx_busy=0, tx_done=0, rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0. Both FSMs go to IDLE and all counters clear.
- Reset mid-frame: the frame is aborted, no tx_done and no rx_valid are produced, and txd is 1 on the cycle after rst is sampled.
- Frame format: start bit (0), DATA_BITS bits LSB first, optional parity bit, STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is F = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Parity: odd means the data bits plus the parity bit contain an odd number of 1s; even means an even number.
- TX FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - tx_start sampled high in IDLE at cycle 0 latches tx_data.
  - tx_busy=1 and txd=0 from cycle 1.
  - tx_done pulses on cycle F, the same cycle tx_busy returns to 0.
  - A tx_start on that cycle is accepted, so back-to-back frames have no idle gap.
  - tx_start while busy is ignored; later changes to tx_data do not affect the frame in flight.
- RX input path: a mux selects loopback ? txd : rxd, followed by a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> (WAIT_IDLE) -> IDLE.
  - IDLE: leave on a synchronised 1->0 transition.
  - START: sample at CLKS_PER_BIT/2 cycles after the edge. If the sample is 1, it is a false start: return to IDLE with no output.
  - Later bits are sampled every CLKS_PER_BIT cycles from the start-bit sample point.
- Frame completion: at the final stop-bit sample, register rx_data, rx_parity_err and rx_frame_err, and pulse rx_valid on the next cycle.
- Parity and framing checks:
  - rx_parity_err is always 0 when PARITY=0.
  - rx_frame_err is set if any stop bit is sampled 0. rx_data is still updated and rx_valid still pulses.
- Recovery after a frame error: the FSM enters WAIT_IDLE and stays until the synchronised line is 1, so a break condition does not retrigger.
- Loopback latency: rx_valid pulses between F - CLKS_PER_BIT/2 + 2 and F - CLKS_PER_BIT/2 + 4 cycles after tx_start is accepted, i.e. before tx_done.
- TX and RX operate independently; simultaneous activity is legal.

Test Plan:
1. Loopback, 8N1: CLKS_PER_BIT=16, DATA_BITS=8, PARITY=0, STOP_BITS=1, loopback=1, send 8'h41 → tx_done on cycle 160; rx_valid inside the loopback-latency window; rx_data=8'h41; both error flags 0.
2. Even parity, external: PARITY=2, drive rxd with a 0x41 frame whose parity bit is 1 (correct value is 0) → rx_valid with rx_data=8'h41 and rx_parity_err=1. Repeat with parity bit 0 → rx_parity_err=0.
3. Framing error: STOP_BITS=2, drive 0xA5 with the second stop bit 0, then hold rxd low for 40 cycles → one rx_valid with rx_frame_err=1; no further rx_valid until rxd returns high and a new start bit arrives.
4. False start: drive a 3-cycle low glitch on rxd → no rx_valid; a valid 0x3C frame immediately after is received correctly.
5. Back-to-back: assert tx_start with 8'h41 and again on the tx_done cycle with 8'hA5 → txd never idles between frames; loopback receives 0x41 then 0xA5.
6. Reset mid-frame: assert rst during the DATA state of a 0x55 transmit → next cycle txd=1, tx_busy=0, and no tx_done or rx_valid from that frame; a following 0x0F transfer succeeds.

Source files
------------

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: configurable divisor, data width, parity and
// stop bits, with parity/framing error detection and internal loopback.
module uart_core_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd,
    input  logic                 rxd,
    input  logic                 loopback,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    // Last stop bit ends one cycle early in-state; the final cycle is spent in
    // IDLE so tx_done/!tx_busy coincide with it and back-to-back has no gap.
    localparam logic [CW-1:0] CNT_CUT   = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          HAS_PAR   = (PARITY != 0);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
    } state_e;

    // ---------------- transmitter ----------------
    state_e               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_done_q, tx_done_d;
    logic                 txd_q, txd_d;

    // TX next state; txd is derived from the next state so the pin is registered
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_done_d  = 1'b0;
        txd_d      = 1'b1;
        case (tx_state_q)
            S_IDLE: begin
                if (tx_start) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ PAR_ODD;
                end
            end
            S_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == DATA_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = S_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (tx_idx_q == STOP_LAST && tx_cnt_q == CNT_CUT) begin
                    tx_state_d = S_IDLE;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_done_d  = 1'b1;
                end else if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_idx_d = tx_idx_q + 4'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        case (tx_state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = tx_shift_d[0];
            S_PARITY: txd_d = tx_par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_done_q  <= tx_done_d;
            txd_q      <= txd_d;
        end
    end

    assign tx_busy = (tx_state_q != S_IDLE);
    assign tx_done = tx_done_q;
    assign txd     = txd_q;

    // ---------------- receiver ----------------
    logic rx_in;
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    assign rx_in = loopback ? txd_q : rxd;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_in;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    state_e               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_facc_q, rx_facc_d;   // earlier stop bits seen low
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;

    // RX next state: mid-bit sampling anchored on the start-bit sample point
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_facc_d  = rx_facc_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d  = '0;
                    rx_idx_d  = '0;
                    rx_facc_d = 1'b0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == DATA_LAST) begin
                        rx_idx_d   = '0;
                        rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_par_d   = rx_s2_q;
                    rx_state_d = S_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_idx_q == STOP_LAST) begin
                        rx_idx_d   = '0;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_shift_q;
                        rx_perr_d  = HAS_PAR & ((^rx_shift_q) ^ rx_par_q ^ PAR_ODD);
                        rx_ferr_d  = rx_facc_q | ~rx_s2_q;
                        // a break would otherwise look like a fresh start bit
                        rx_state_d = (rx_facc_q | ~rx_s2_q) ? S_WAIT : S_IDLE;
                    end else begin
                        rx_facc_d = rx_facc_q | ~rx_s2_q;
                        rx_idx_d  = rx_idx_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (rx_s2_q) rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_facc_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_facc_q  <= rx_facc_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule
